// File: rtl/dbus_timer.sv
// -----------------------------------------------------------------------------
// dbus_timer
//   Memory-mapped timer/compare responder on the core data bus. It decodes a
//   32-byte window at BASE_ADDR and runs a prescaled 32-bit up-counter. When
//   the counter matches COMPARE, a sticky MATCH flag is set. MATCH gated by
//   IRQ_EN drives a level interrupt.
//
//   Register map (word offsets within the window):
//     0x00 CTRL      bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN
//     0x04 PRESCALE  [PRESC_W-1:0]
//     0x08 COUNT     32-bit counter, read/write
//     0x0C COMPARE   32-bit compare value
//     0x10 STATUS    bit0 MATCH, write 1 to clear
//     0x14..0x1C     read as zero, writes ignored
//
// Parameters:
//   BASE_ADDR    window base; only bits [31:5] take part in the decode
//   PRESC_W      prescaler width, 1..32
//
// Ports:
//   i_Clk        system clock, rising edge
//   i_Rstn       asynchronous active-low reset
//   i_ReadEn     bus read request
//   i_WriteEn    bus write request (full word)
//   i_Addr       byte address; bits [1:0] are ignored
//   i_DataWrite  write data
//   o_DataRead   registered read data; zero whenever o_Hit is low
//   o_Hit        registered; high for one cycle after a read of this window
//   o_Interrupt  MATCH & IRQ_EN, level
// -----------------------------------------------------------------------------
module dbus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter int          PRESC_W   = 16
) (
    input  logic        i_Clk,
    input  logic        i_Rstn,
    input  logic        i_ReadEn,
    input  logic        i_WriteEn,
    input  logic [31:0] i_Addr,
    input  logic [31:0] i_DataWrite,
    output logic [31:0] o_DataRead,
    output logic        o_Hit,
    output logic        o_Interrupt
);

    localparam logic [2:0] OFF_CTRL  = 3'd0;
    localparam logic [2:0] OFF_PRESC = 3'd1;
    localparam logic [2:0] OFF_COUNT = 3'd2;
    localparam logic [2:0] OFF_CMP   = 3'd3;
    localparam logic [2:0] OFF_STAT  = 3'd4;

    localparam logic [PRESC_W-1:0] PC_ONE = 1;

    // The field order puts EN in bit 0, AUTO_RELOAD in bit 1 and IRQ_EN in
    // bit 2, so the struct overlays the low three bits of the bus word.
    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic en;
    } ctrl_t;

    ctrl_t              ctrl;
    logic [PRESC_W-1:0] prescale;
    logic [PRESC_W-1:0] pc;
    logic [31:0]        count;
    logic [31:0]        compare;
    logic               match;

    logic               sel;
    logic [2:0]         off;
    logic               wr_acc;
    logic               rd_acc;
    logic               tick;
    logic               cmp_hit;
    logic [31:0]        count_nxt;
    logic [31:0]        presc_ext;
    logic [31:0]        rd_mux;

    // The byte-lane bits are never decoded, because all accesses are
    // full-word accesses.
    logic               unused_addr_lsb;
    assign unused_addr_lsb = ^i_Addr[1:0];

    // ---------------------------------------------------------------- decode
    assign sel    = (i_Addr[31:5] == BASE_ADDR[31:5]);
    assign off    = i_Addr[4:2];
    assign wr_acc = i_WriteEn & sel;
    // When read and write are both asserted, only the write is performed,
    // so the read is suppressed here.
    assign rd_acc = i_ReadEn & sel & ~i_WriteEn;

    // ------------------------------------------------------------- prescaler
    assign tick    = ctrl.en && (pc == prescale);
    assign cmp_hit = tick && (count == compare);

    always_ff @(posedge i_Clk or negedge i_Rstn) begin
        if (!i_Rstn) begin
            pc <= '0;
        end else if (wr_acc && off == OFF_PRESC) begin
            // A PRESCALE write restarts the divider. If a tick occurs in the
            // same cycle, that tick still counts, because tick is taken from
            // the old pc value.
            pc <= '0;
        end else if (ctrl.en) begin
            pc <= tick ? '0 : pc + PC_ONE;
        end
    end

    // --------------------------------------------------------------- counter
    // A bus write to COUNT has priority over the tick update. The compare
    // for that tick still uses the old count, so MATCH can still be set.
    always_comb begin
        count_nxt = count;
        if (tick) begin
            count_nxt = (cmp_hit && ctrl.auto_reload) ? 32'd0 : count + 32'd1;
        end
        if (wr_acc && off == OFF_COUNT) begin
            count_nxt = i_DataWrite;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rstn) begin
        if (!i_Rstn) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

    // ------------------------------------------------------------- registers
    always_ff @(posedge i_Clk or negedge i_Rstn) begin
        if (!i_Rstn) begin
            ctrl     <= '0;
            prescale <= '0;
            compare  <= 32'hFFFF_FFFF;
        end else if (wr_acc) begin
            case (off)
                OFF_CTRL:  ctrl     <= ctrl_t'(i_DataWrite[2:0]);
                OFF_PRESC: prescale <= i_DataWrite[PRESC_W-1:0];
                OFF_CMP:   compare  <= i_DataWrite;
                default:   ;
            endcase
        end
    end

    // MATCH is sticky. If a match occurs in the same cycle as a
    // write-1-to-clear, setting the flag takes priority over clearing it.
    always_ff @(posedge i_Clk or negedge i_Rstn) begin
        if (!i_Rstn) begin
            match <= 1'b0;
        end else if (cmp_hit) begin
            match <= 1'b1;
        end else if (wr_acc && off == OFF_STAT && i_DataWrite[0]) begin
            match <= 1'b0;
        end
    end

    // ------------------------------------------------------------- read path
    always_comb begin
        presc_ext              = '0;
        presc_ext[PRESC_W-1:0] = prescale;
    end

    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_CTRL:  rd_mux = {29'd0, ctrl};
            OFF_PRESC: rd_mux = presc_ext;
            OFF_COUNT: rd_mux = count;
            OFF_CMP:   rd_mux = compare;
            OFF_STAT:  rd_mux = {31'd0, match};
            default:   rd_mux = '0;
        endcase
    end

    // When this block is not responding, the data output is driven to zero.
    // This lets the core OR this output with the data-memory read data.
    always_ff @(posedge i_Clk or negedge i_Rstn) begin
        if (!i_Rstn) begin
            o_Hit      <= 1'b0;
            o_DataRead <= '0;
        end else begin
            o_Hit      <= rd_acc;
            o_DataRead <= rd_acc ? rd_mux : 32'd0;
        end
    end

    // The interrupt is combinational from register bits, with no added delay.
    assign o_Interrupt = match & ctrl.irq_en;

endmodule

// File: tb/tb_dbus_timer.sv
module tb_dbus_timer;

    localparam logic [31:0] BASE = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        hit;
    logic        irq;

    dbus_timer #(.BASE_ADDR(BASE), .PRESC_W(16)) dut (
        .i_Clk       (clk),
        .i_Rstn      (rst_n),
        .i_ReadEn    (rd_en),
        .i_WriteEn   (wr_en),
        .i_Addr      (addr),
        .i_DataWrite (wdata),
        .o_DataRead  (rdata),
        .o_Hit       (hit),
        .o_Interrupt (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          tag;
        logic        hit;
        logic [31:0] data;
        logic        ci;
        logic        ei;
    } exp_t;

    exp_t q[$];
    int   seq = 0;
    int   total = 0;
    int   bad = 0;
    logic finish_req = 1'b0;
    exp_t me;

    // Monitor: at each falling edge, check the responses that are due on
    // the rising edge just passed.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            me = q.pop_front();
            total++;
            if (me.due != cyc) begin
                bad++;
                $display("FAIL stale#%0d due=%0d now=%0d", me.tag, me.due, cyc);
            end else if (hit !== me.hit || rdata !== me.data) begin
                bad++;
                $display("FAIL bus#%0d cyc=%0d got hit=%0b data=%h want hit=%0b data=%h",
                         me.tag, cyc, hit, rdata, me.hit, me.data);
            end
            if (me.ci) begin
                total++;
                if (irq !== me.ei) begin
                    bad++;
                    $display("FAIL irq#%0d cyc=%0d got=%0b want=%0b", me.tag, cyc, irq, me.ei);
                end
            end
        end
        if (finish_req) begin
            if (q.size() != 0) begin
                total++;
                bad++;
                $display("FAIL drain left=%0d", q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    // Drive one bus cycle and queue the response expected after the edge
    // that samples it.
    task automatic op(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic eh, input logic [31:0] ed, input logic ci, input logic ei);
        exp_t e;
        @(posedge clk);
        #1;
        rd_en = r; wr_en = w; addr = a; wdata = d;
        e.due = cyc + 1; e.tag = seq; e.hit = eh; e.data = ed; e.ci = ci; e.ei = ei;
        q.push_back(e);
        seq++;
    endtask

    task automatic rd(input logic [31:0] o, input logic [31:0] x, input logic ci = 1'b0, input logic ei = 1'b0);
        op(1'b1, 1'b0, BASE + o, 32'd0, 1'b1, x, ci, ei);
    endtask

    task automatic wr(input logic [31:0] o, input logic [31:0] d, input logic ci = 1'b0, input logic ei = 1'b0);
        op(1'b0, 1'b1, BASE + o, d, 1'b0, 32'd0, ci, ei);
    endtask

    task automatic idle(input int n, input logic ci, input logic ei);
        for (int i = 0; i < n; i++) op(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, ci, ei);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Check reset values read back through the bus.
        rd(32'h00, 32'h0, 1'b1, 1'b0);
        rd(32'h04, 32'h0);
        rd(32'h08, 32'h0);
        rd(32'h0C, 32'hFFFF_FFFF);
        rd(32'h10, 32'h0);
        rd(32'h14, 32'h0);
        rd(32'h18, 32'h0);
        rd(32'h1C, 32'h0);
        idle(1, 1'b1, 1'b0);

        // Periodic interrupt: (4+1)*(3+1) = 20 cycles per match.
        wr(32'h04, 32'd3);
        wr(32'h0C, 32'd4);
        wr(32'h00, 32'd7, 1'b1, 1'b0);   // edge E0
        idle(19, 1'b1, 1'b0);            // E1..E19
        idle(1, 1'b1, 1'b1);             // E20: interrupt rises
        wr(32'h10, 32'd1, 1'b1, 1'b0);   // E21: clear, interrupt low
        idle(18, 1'b1, 1'b0);            // E22..E39
        idle(1, 1'b1, 1'b1);             // E40: interrupt rises again
        wr(32'h00, 32'd0, 1'b1, 1'b0);   // E41: IRQ_EN off, interrupt falls
        rd(32'h10, 32'd1, 1'b1, 1'b0);   // MATCH still set

        // One-shot wrap from FFFF_FFFE with COMPARE=0, IRQ disabled.
        wr(32'h04, 32'd0);
        wr(32'h0C, 32'd0);
        wr(32'h08, 32'hFFFF_FFFE);
        wr(32'h10, 32'd1);
        rd(32'h10, 32'd0);
        wr(32'h00, 32'd1);               // W
        idle(2, 1'b1, 1'b0);             // ticks 1, 2
        rd(32'h08, 32'd0);               // W+3: count is 0 before tick 3 matches
        rd(32'h10, 32'd1, 1'b1, 1'b0);   // MATCH set, interrupt masked
        // A COUNT write at the same edge as a tick: the written value wins.
        wr(32'h08, 32'h55);
        rd(32'h08, 32'h55);
        wr(32'h00, 32'd0);

        // A STATUS clear at the same edge as a match: the set wins.
        wr(32'h0C, 32'h10);
        wr(32'h08, 32'h0E);
        wr(32'h10, 32'd1);
        rd(32'h10, 32'd0);
        wr(32'h00, 32'd1);               // X
        idle(2, 1'b0, 1'b0);             // 0E->0F->10
        wr(32'h10, 32'd1);               // X+3: match and clear together
        rd(32'h10, 32'd1);               // X+4
        wr(32'h00, 32'd0);               // X+5
        rd(32'h08, 32'h13);

        // Read and write asserted together: the write lands and there is no hit.
        op(1'b1, 1'b1, BASE + 32'h0C, 32'h0000_ABCD, 1'b0, 32'd0, 1'b0, 1'b0);
        rd(32'h0C, 32'h0000_ABCD);

        // Address decode at the window edges.
        op(1'b0, 1'b1, BASE + 32'h20, 32'd7, 1'b0, 32'd0, 1'b0, 1'b0);
        op(1'b0, 1'b1, BASE - 32'h4, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0, 1'b0);
        op(1'b1, 1'b0, BASE + 32'h20, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        op(1'b1, 1'b0, BASE - 32'h4, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        rd(32'h00, 32'd0);
        rd(32'h0C, 32'h0000_ABCD);
        wr(32'h08, 32'h77);
        op(1'b1, 1'b0, BASE + 32'h0B, 32'd0, 1'b1, 32'h77, 1'b0, 1'b0);
        wr(32'h14, 32'h1234_5678);
        rd(32'h14, 32'd0);

        // Assert asynchronous reset while the interrupt and o_Hit are high.
        wr(32'h0C, 32'd2);
        wr(32'h08, 32'd0);
        wr(32'h10, 32'd1);
        wr(32'h00, 32'd5, 1'b1, 1'b0);   // R
        idle(2, 1'b1, 1'b0);             // R+1, R+2
        idle(2, 1'b1, 1'b1);             // R+3 match, R+4
        // This read is sampled at edge N. Reset goes low 2 ns later, so by the
        // falling edge, o_Hit and the interrupt must already be low.
        op(1'b1, 1'b0, BASE + 32'h10, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1 rd_en = 1'b0; addr = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rd(32'h00, 32'h0);
        rd(32'h04, 32'h0);
        rd(32'h08, 32'h0);
        rd(32'h0C, 32'hFFFF_FFFF);
        rd(32'h10, 32'h0, 1'b1, 1'b0);
        idle(1, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        finish_req = 1'b1;
    end

endmodule

// File: doc/dbus_timer.md
# dbus_timer

Memory-mapped timer/compare peripheral that sits on the core's data bus (DBUS) as a responder, alongside the data memory. It decodes its own address window, services single-cycle word reads and writes from the core, runs a prescaled 32-bit up-counter, and raises a level interrupt on compare match. The interrupt feeds the core's interrupt input.

## Interface
- BASE_ADDR, 32'h0001_0000, window base; the block is selected when i_Addr[31:5] == BASE_ADDR[31:5].
- PRESC_W, 16, prescaler register width; legal range 1..32.
- i_Clk  in  1  single system clock, rising edge.
- i_Rstn  in  1  asynchronous, active-low reset.
- i_ReadEn  in  1  DBUS read request from the core.
- i_WriteEn  in  1  DBUS write request from the core.
- i_Addr  in  32  DBUS byte address. Bits [1:0] are ignored.
- i_DataWrite  in  32  DBUS write data. Writes are full-word only.
- o_DataRead  out  32  registered read data.
- o_Hit  out  1  registered; when 1, o_DataRead carries this block's response.
- o_Interrupt  out  1  level interrupt to the core.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- Select: sel = (i_Addr[31:5] == BASE_ADDR[31:5]). The register offset is i_Addr[4:2].
- Register map:
  - 0x00 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN. Other bits read 0.
  - 0x04 PRESCALE: [PRESC_W-1:0]. Upper bits read 0.
  - 0x08 COUNT: 32 bits, read/write.
  - 0x0C COMPARE: 32 bits, read/write.
  - 0x10 STATUS: bit0 MATCH, sticky. Writing 1 to bit0 clears it; writing 0 has no effect.
  - 0x14–0x1C: reads return 0, writes are ignored.
- Reset values: CTRL=0, PRESCALE=0, COUNT=0, COMPARE=32'hFFFF_FFFF, MATCH=0, internal prescale counter pc=0, o_DataRead=0, o_Hit=0, o_Interrupt=0.
- Prescaler:
  - When EN=1: if pc==PRESCALE, then pc<=0 and a tick occurs; otherwise pc<=pc+1.
  - When EN=0: pc and COUNT hold.
- On a tick:
  - If COUNT==COMPARE: MATCH<=1, and COUNT<=(AUTO_RELOAD ? 0 : COUNT+1).
  - Otherwise: COUNT<=COUNT+1.
  - Addition wraps modulo 2^32 (32'hFFFF_FFFF -> 0).
- Interrupt: o_Interrupt = MATCH & IRQ_EN, combinational from register bits. No other logic sits in this path.
- Write (i_WriteEn & sel): the addressed register updates at the clock edge.
  - Writing PRESCALE also forces pc<=0.
- Read (i_ReadEn & sel & ~i_WriteEn): o_DataRead<=register value and o_Hit<=1.
  - In every other cycle, o_DataRead<=0 and o_Hit<=0. This allows an OR-mux with the data memory.
- Simultaneous events:
  - A COUNT write in the same cycle as a tick: the written value wins; the MATCH evaluation from that tick still applies.
  - STATUS clear in the same cycle as a match set: set wins, so MATCH stays 1.
  - ReadEn and WriteEn both asserted: only the write is performed; o_Hit=0 the next cycle.
  - A PRESCALE write in the same cycle as a tick: the tick occurs, and pc ends at 0.

## Timing
- Read latency is one cycle: request at edge N, data and o_Hit valid after edge N+1 for one cycle.
- A write takes effect at the edge that samples it; a read issued the following cycle returns the new value.
- With AUTO_RELOAD=1, MATCH is set every (COMPARE+1)*(PRESCALE+1) cycles after EN rises, starting from COUNT=0 and pc=0.
- o_Interrupt rises in the same cycle MATCH becomes 1 (with IRQ_EN=1). It falls the cycle after a STATUS clear or an IRQ_EN clear.
- The block never stalls the bus; there is no wait state.
- Asserting i_Rstn low mid-operation immediately returns all registers and outputs to their reset values, independent of the clock.

## Test plan
- Reset/readback: after reset, read all six offsets -> CTRL=0, PRESCALE=0, COUNT=0, COMPARE=FFFF_FFFF, STATUS=0, 0x14=0. o_Hit=1 exactly one cycle after each read; o_DataRead=0 otherwise.
- Periodic IRQ: PRESCALE=3, COMPARE=4, CTRL=7 -> first o_Interrupt rise exactly 20 cycles after the CTRL write edge. Write STATUS=1 -> o_Interrupt=0 the next cycle. The next rise comes 20 cycles after the previous one.
- One-shot wrap: COUNT=FFFF_FFFE, COMPARE=0, PRESCALE=0, CTRL=1 -> COUNT reads 0 after 2 ticks and MATCH sets on the 3rd tick. o_Interrupt stays 0 because IRQ_EN=0.
- Collisions:
  - COUNT write of 0x55 coincident with a tick -> COUNT reads 0x55.
  - STATUS clear coincident with a match -> MATCH reads 1.
  - ReadEn+WriteEn together -> register written, o_Hit=0.
- Decode: access at BASE_ADDR+0x20 and BASE_ADDR-4 -> no register changes, o_Hit=0. Access at BASE_ADDR+0x0B -> hits COUNT.
- Async reset: assert i_Rstn low between clock edges while o_Interrupt=1 -> o_Interrupt and o_Hit drop to 0 immediately; all registers read reset values after release.
